// File: rtl/next_pc_gen.sv
// Fetch-PC generator: selects execute redirect, decode JAL, RAS return or PC+4.
// Optional return-address stack is enabled by defining NEXT_PC_RAS_EN.
module next_pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h4000_0000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] fetch_pc,
  output logic [1:0]      pc_sel,
  output logic            id_kill
);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_JAL = 2'b01,
    SEL_EX  = 2'b10,
    SEL_RAS = 2'b11
  } sel_e;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            id_kill_q, id_kill_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  sel_e            sel;

  logic            eff;
  logic [XLEN-1:0] eff_tgt;
  logic            dec_ok, dec_act, is_jal, is_jalr;
  logic [XLEN-1:0] j_imm;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;

  assign eff     = ex_redirect | pend_valid_q;
  assign eff_tgt = ex_redirect ? ex_target : pend_target_q;
  assign dec_ok  = id_valid & ~id_kill_q & ~eff;
  assign dec_act = dec_ok & ~stall;
  assign is_jal  = (id_inst[6:0] == OP_JAL);
  assign is_jalr = (id_inst[6:0] == OP_JALR);
  assign j_imm   = XLEN'($signed({id_inst[31], id_inst[19:12], id_inst[20],
                                  id_inst[30:21], 1'b0}));

`ifdef NEXT_PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d, ras_wr_idx;
  logic [PW:0]     ras_cnt_q, ras_cnt_d;
  logic            ras_push, ras_pop_req, ras_wr_en;
  logic [4:0]      rd, rs1;
  logic            rd_link, rs1_link;

  assign rd       = id_inst[11:7];
  assign rs1      = id_inst[19:15];
  assign rd_link  = (rd == 5'd1) | (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) | (rs1 == 5'd5);

  // ras_ptr_q is the next free slot; the top of stack sits one below it.
  assign ras_top     = ras_q[ras_ptr_q - PW'(1)];
  assign ras_push    = dec_act & (is_jal | is_jalr) & rd_link;
  assign ras_pop_req = dec_act & is_jalr & rs1_link &
                       ((rd == 5'd0) | (rd_link & (rd != rs1)));
  assign ras_pop     = ras_pop_req & (ras_cnt_q != '0);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = ras_ptr_q;
    if (ras_pop && ras_push) begin
      ras_wr_en  = 1'b1;
      ras_wr_idx = ras_ptr_q - PW'(1);
    end else if (ras_push) begin
      ras_wr_en  = 1'b1;
      ras_ptr_d  = ras_ptr_q + PW'(1);
      if (ras_cnt_q != (PW+1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + (PW+1)'(1);
    end else if (ras_pop) begin
      ras_ptr_d = ras_ptr_q - PW'(1);
      ras_cnt_d = ras_cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // NOTE: stack storage is not reset; ras_cnt_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (ras_wr_en) ras_q[ras_wr_idx] <= id_pc + XLEN'(4);
  end
`else
  logic unused_rd;
  assign unused_rd = ^id_inst[11:7];
  assign ras_pop   = 1'b0;
  assign ras_top   = '0;
`endif

  always_comb begin
    sel           = SEL_SEQ;
    fetch_pc_d    = fetch_pc_q + XLEN'(4);
    id_kill_d     = id_kill_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (stall) begin
      fetch_pc_d = fetch_pc_q;
      if (ex_redirect) begin
        pend_valid_d  = 1'b1;
        pend_target_d = ex_target;
      end
    end else begin
      if (eff) begin
        sel        = SEL_EX;
        fetch_pc_d = eff_tgt;
      end else if (dec_ok && is_jal) begin
        sel        = SEL_JAL;
        fetch_pc_d = id_pc + j_imm;
      end else if (ras_pop) begin
        sel        = SEL_RAS;
        fetch_pc_d = ras_top;
      end
      pend_valid_d = 1'b0;
      id_kill_d    = (sel != SEL_SEQ);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      id_kill_q     <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      id_kill_q     <= id_kill_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign fetch_pc = fetch_pc_q;
  assign id_kill  = id_kill_q;
  assign pc_sel   = rst ? SEL_SEQ : sel;

endmodule

// File: tb/tb_next_pc_gen.sv
// Scoreboard bench for next_pc_gen: directed scenarios plus randomized traffic
// checked against a behavioural model (RAS model active with NEXT_PC_RAS_EN).
module tb_next_pc_gen;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h4000_0000;
  localparam int          RAS_DEPTH = 4;

  typedef enum {K_OTHER, K_JAL, K_JALR} kind_e;
  typedef struct {
    logic [31:0] pc;
    logic        kill;
    logic [1:0]  sel;
  } exp_t;

  logic        clk, rst, stall, id_valid, ex_redirect;
  logic [31:0] id_inst, id_pc, ex_target, fetch_pc;
  logic [1:0]  pc_sel;
  logic        id_kill;

  next_pc_gen #(.XLEN(XLEN), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .fetch_pc(fetch_pc), .pc_sel(pc_sel), .id_kill(id_kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_kill, m_pv;
  logic [31:0] m_pt;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input kind_e k, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [31:0] imm);
    case (k)
      K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      K_JALR:  return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_kill = 0; m_pv = 0; m_pt = '0;
    m_ras.delete();
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs and advance the model.
  task automatic apply(input bit st, input bit idv, input kind_e k, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] imm, input logic [31:0] ipc,
                       input bit exr, input logic [31:0] ext);
    exp_t        e;
    logic [1:0]  s;
    logic [31:0] nxt;
    bit          dec;
    stall = st; id_valid = idv; id_inst = enc(k, rd, rs1, imm); id_pc = ipc;
    ex_redirect = exr; ex_target = ext;
    e.pc = m_pc; e.kill = m_kill;
    s = 2'b00; nxt = m_pc + 32'd4;
    if (st) begin
      nxt = m_pc;
      if (exr) begin m_pv = 1; m_pt = ext; end
    end else begin
      dec = idv && !m_kill && !(exr || m_pv);
      if (exr || m_pv) begin
        s = 2'b10; nxt = exr ? ext : m_pt;
      end else if (dec && k == K_JAL) begin
        s = 2'b01; nxt = ipc + imm;
      end
`ifdef NEXT_PC_RAS_EN
      if (dec && k == K_JALR && is_link(rs1) && (rd == 0 || (is_link(rd) && rd != rs1))
          && m_ras.size() > 0) begin
        s = 2'b11; nxt = m_ras.pop_back();
      end
      if (dec && (k == K_JAL || k == K_JALR) && is_link(rd)) begin
        m_ras.push_back(ipc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
      end
`endif
      m_pv = 0;
      m_kill = (s != 2'b00);
    end
    e.sel = s;
    m_pc = nxt;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    apply(0, 0, K_OTHER, 5'd0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("fetch_pc", fetch_pc, mon_e.pc);
      check("id_kill", 32'(id_kill), 32'(mon_e.kill));
      check("pc_sel", 32'(pc_sel), 32'(mon_e.sel));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] regs [4];
    kind_e      k;
    int         r;
    logic [19:0] bits;
    logic [31:0] imm;
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7;

    rst = 1; stall = 0; id_valid = 0; id_inst = '0; id_pc = '0;
    ex_redirect = 0; ex_target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    check("reset fetch_pc", fetch_pc, RESET_PC);

    // 1: mid-cycle reset pulse, then free-running increments
    repeat (3) begin idle(); tick(); end
    #2 rst = 1;
    #1;
    check("async reset fetch_pc", fetch_pc, RESET_PC);
    check("reset pc_sel", 32'(pc_sel), 32'd0);
    check("reset id_kill", 32'(id_kill), 32'd0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      idle(); tick();
      check("post-reset fetch_pc", fetch_pc, RESET_PC + 32'(4 * i));
    end

    // 2: decode JAL, then a JAL ignored while id_kill is set
    apply(0, 1, K_JAL, 5'd0, 5'd0, 32'h100, 32'h4000_0010, 0, 32'd0);
    #1 check("jal pc_sel", 32'(pc_sel), 32'd1);
    tick();
    check("jal fetch_pc", fetch_pc, 32'h4000_0110);
    check("jal id_kill", 32'(id_kill), 32'd1);
    apply(0, 1, K_JAL, 5'd0, 5'd0, 32'h100, 32'h4000_0010, 0, 32'd0);
    #1 check("killed jal pc_sel", 32'(pc_sel), 32'd0);
    tick();
    check("killed jal fetch_pc", fetch_pc, 32'h4000_0114);

    // 3: execute redirect beats decode JAL
    apply(0, 1, K_JAL, 5'd0, 5'd0, 32'h100, 32'h4000_0010, 1, 32'h4000_0800);
    #1 check("redirect pc_sel", 32'(pc_sel), 32'd2);
    tick();
    check("redirect fetch_pc", fetch_pc, 32'h4000_0800);
    idle(); tick();

    // 4: redirects during stall, last one wins
    apply(1, 0, K_OTHER, 5'd0, 5'd0, 32'd0, 32'd0, 1, 32'h4000_0200); tick();
    apply(1, 0, K_OTHER, 5'd0, 5'd0, 32'd0, 32'd0, 1, 32'h4000_0300); tick();
    apply(1, 0, K_OTHER, 5'd0, 5'd0, 32'd0, 32'd0, 0, 32'd0); tick();
    check("stall hold fetch_pc", fetch_pc, 32'h4000_0804);
    idle();
    #1 check("pending pc_sel", 32'(pc_sel), 32'd2);
    tick();
    check("pending fetch_pc", fetch_pc, 32'h4000_0300);

    // 5: wrap-around
    apply(0, 0, K_OTHER, 5'd0, 5'd0, 32'd0, 32'd0, 1, 32'hFFFF_FFFC); tick();
    idle(); tick();
    check("wrap fetch_pc", fetch_pc, 32'h0000_0000);

`ifdef NEXT_PC_RAS_EN
    // 6: call/return and RAS overflow
    apply(0, 1, K_JAL, 5'd1, 5'd0, 32'h100, 32'h4000_0040, 0, 32'd0); tick();
    idle(); tick();
    apply(0, 1, K_JALR, 5'd0, 5'd1, 32'd0, 32'h4000_0140, 0, 32'd0);
    #1 check("ret pc_sel", 32'(pc_sel), 32'd3);
    tick();
    check("ret fetch_pc", fetch_pc, 32'h4000_0044);
    idle(); tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, K_JAL, 5'd1, 5'd0, 32'h10, 32'h4000_1000 + 32'(i * 'h100), 0, 32'd0);
      tick(); idle(); tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, K_JALR, 5'd0, 5'd1, 32'd0, 32'h4000_2000, 0, 32'd0);
      #1 check("nested ret pc_sel", 32'(pc_sel), (i < 4) ? 32'd3 : 32'd0);
      tick();
      if (i < 4) check("nested ret fetch_pc", fetch_pc, 32'h4000_1000 + 32'((4 - i) * 'h100) + 32'd4);
      idle(); tick();
    end
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      k = (r < 25) ? K_JAL : (r < 60) ? K_JALR : K_OTHER;
      bits = 20'($urandom_range(0, 20'hFFFFF));
      imm = (k == K_JAL) ? {{11{bits[19]}}, bits, 1'b0} : {20'd0, bits[11:0]};
      apply($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70, k,
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], imm,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} , $urandom_range(0, 99) < 10,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      tick();
    end

    idle(); tick();
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
